fpu_divsqrt: RTL and testbench
==============================

Name: fpu_divsqrt

Overview:
Parametrised iterative FP divide/square-root unit; successor to the single-mode divider, adding a sqrt mode, IEEE special-case handling with a 1-cycle early-out, a kill/flush input, and a sticky bit. It sits beside the other multi-cycle FPU units and produces an unrounded quotient or root plus a wide exponent. The shared FPU normalise/round stage consumes the result.

Parameters:
EXP_W, 8, exponent field width
MANT_W, 23, stored mantissa field width (hidden bit excluded)
DEST_W, 5, destination register tag width
(derived: BIAS = 2^(EXP_W-1)-1; N = MANT_W+3 iterations; QW = MANT_W+4 result width)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fpu_div_start  in  1  accept operation this cycle
fpu_div_mode  in  1  0 = divide a/b, 1 = sqrt(a) (b ignored)
fpu_a  in  1+EXP_W+MANT_W  operand A, IEEE layout {sign, exp, mant}
fpu_b  in  1+EXP_W+MANT_W  operand B
fpu_dest  in  DEST_W  destination tag
fpu_div_kill  in  1  flush any in-flight operation
div_valid  out  1  one-cycle result strobe
div_mantissa  out  QW  {quotient/root bits weight 2^0..2^-(MANT_W+2), sticky}
div_exponent  out  EXP_W+2  signed biased exponent, unclamped (under/overflow visible)
div_sign  out  1  result sign
div_special  out  2  0 normal, 1 zero, 2 infinity, 3 NaN
div_dest  out  DEST_W  tag of the completing op
fpu_div_busy  out  1  fpu_div_start OR state != IDLE (combinational)

Behaviour:
- Clocking/reset: one clock, clock; reset_n is asynchronous and active-low. On reset: state IDLE, count 0, and every registered output 0. fpu_div_busy then equals fpu_div_start.
- States: IDLE, RUN, SPECIAL, DONE.
- IDLE + start: latch operands, mode and dest; classify the operands; go to SPECIAL if the result is special, else RUN with count = N.
- Denormal inputs (exp == 0) are flushed to zero before classification.
- Divide classes, in priority order:
  - NaN if either operand is NaN, or 0/0, or inf/inf.
  - Inf if a is inf, or b is zero.
  - Zero if a is zero, or b is inf.
  - Sign = sa ^ sb for zero and inf results.
- Sqrt classes:
  - NaN if a is NaN, or a is negative and nonzero.
  - ±0 gives zero, keeping the sign of a.
  - +inf gives inf, sign 0.
- NaN results always have sign 0.
- Special results: div_mantissa = 0, div_exponent = 0. SPECIAL -> IDLE with div_valid = 1. Latency 1: start at edge k gives valid in the cycle after edge k+1.
- Divide datapath, normal case:
  - Remainder initialised to {1, ma}; divisor = {1, mb}.
  - Each RUN cycle: trial subtract remainder − divisor. If the result is non-negative, keep it and shift in quotient bit 1; otherwise keep the old remainder and shift in 0. The remainder shifts left by 1 either way.
  - Exponent = ea − eb + BIAS, computed signed at EXP_W+2 bits.
  - Sign = sa ^ sb.
- Sqrt datapath, normal case:
  - Restoring digit-by-digit root, 2 radicand bits per step.
  - If the unbiased exponent is odd, the radicand mantissa is shifted left by 1.
  - Exponent = ((ea − BIAS) >>> 1) + BIAS, using floor.
  - Sign = 0.
  - Remainder width is MANT_W+5.
- RUN: decrement count each cycle; at count == 1 go to DONE.
- DONE: div_mantissa[0] = (final remainder != 0), which is the sticky bit. div_valid = 1; go to IDLE.
- Normal latency is N+1 cycles (27 at defaults).
- Quotient range is (0.5, 2), so the top bit may be 0. Normalisation is done downstream.
- div_valid is a single-cycle pulse. All other outputs hold until the next completion.
- fpu_div_start while busy (state != IDLE) is ignored; a bench assertion flags it as a protocol error.
- fpu_div_kill: next state IDLE from any state. No div_valid is produced for the killed op.
  - Kill together with start: kill wins and start is ignored.
  - Kill in DONE or SPECIAL suppresses that cycle's valid.
- Reset asserted mid-operation: immediate return to IDLE, outputs cleared, no valid.

Decomposition:
- Package fpu_pkg holds:
  - the default EXP_W, MANT_W and BIAS constants;
  - the special-class enum (FP_NORMAL, FP_ZERO, FP_INF, FP_NAN);
  - the state enum;
  - the operand classify function.
- One sub-module, fpu_divsqrt_step, is natural: a combinational single iteration (trial subtract plus select) serving both modes, selected by the mode input.

Test Plan:
- Divide 3.0/2.0 (0x40400000, 0x40000000), dest 7 -> valid at cycle 27, div_mantissa 0x6000000, exponent 127, sign 0, special 0, dest 7.
- Divide 1.0/3.0 (0x3F800000, 0x40400000) -> div_mantissa 0x2AAAAAB (sticky 1), exponent 126.
- Sqrt 4.0 (0x40800000) -> div_mantissa 0x4000000, exponent 128. Sqrt 2.0 (0x40000000) -> exponent 127, top bits 1.0110101 (that is, 1.414).
- Specials:
  - 1.0/+0 -> special 2, sign 0, valid 1 cycle after start.
  - 0/0 -> special 3.
  - sqrt(-4.0) -> special 3.
  - sqrt(-0) -> special 1, sign 1.
- Kill at cycle 10 of a divide -> no valid, busy low the next cycle. A new start then completes normally. Kill together with start -> op dropped.
- Start reasserted at cycle 5 while busy -> ignored; the first op's result and dest are unaffected. reset_n pulsed mid-op -> all outputs 0, no valid.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the iterative FP divide/square-root unit:
// default field widths, result classes, FSM states and operand classify.
package fpu_pkg;

   localparam int FP_EXP_W  = 8;
   localparam int FP_MANT_W = 23;
   localparam int FP_BIAS   = 2**(FP_EXP_W-1) - 1;

   // Result class as presented to the normalise/round stage.
   typedef enum logic [1:0] {
      FP_NORMAL = 2'd0,
      FP_ZERO   = 2'd1,
      FP_INF    = 2'd2,
      FP_NAN    = 2'd3
   } fp_class_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_SPECIAL = 2'd2,
      ST_DONE    = 2'd3
   } div_state_e;

   // Width-independent classify: the caller reduces the fields to flags.
   // A zero exponent is treated as zero, so denormals flush before use.
   function automatic fp_class_e fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic mant_zero);
      if (exp_zero)
         return FP_ZERO;
      else if (exp_ones)
         return mant_zero ? FP_INF : FP_NAN;
      else
         return FP_NORMAL;
   endfunction

endpackage

// File: rtl/fpu_divsqrt_if.sv
// Request/result bundle of the divide/sqrt unit.
// Handshake: an operation is taken on a clock edge where fpu_div_start is
// high, the unit is idle and fpu_div_kill is low; fpu_div_busy reports
// (start OR not idle) so a requester holding start sees busy immediately.
// div_valid is a one-cycle strobe; the other result fields hold until the
// next completion. dbg_state mirrors the FSM state for observation.
interface fpu_divsqrt_if #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int DEST_W = 5
);
   import fpu_pkg::*;

   logic                    fpu_div_start;
   logic                    fpu_div_mode;
   logic [EXP_W+MANT_W:0]   fpu_a;
   logic [EXP_W+MANT_W:0]   fpu_b;
   logic [DEST_W-1:0]       fpu_dest;
   logic                    fpu_div_kill;
   logic                    div_valid;
   logic [MANT_W+3:0]       div_mantissa;
   logic [EXP_W+1:0]        div_exponent;
   logic                    div_sign;
   logic [1:0]              div_special;
   logic [DEST_W-1:0]       div_dest;
   logic                    fpu_div_busy;
   div_state_e              dbg_state;

   modport master (
      output fpu_div_start, fpu_div_mode, fpu_a, fpu_b, fpu_dest, fpu_div_kill,
      input  div_valid, div_mantissa, div_exponent, div_sign, div_special,
             div_dest, fpu_div_busy, dbg_state
   );

   modport slave (
      input  fpu_div_start, fpu_div_mode, fpu_a, fpu_b, fpu_dest, fpu_div_kill,
      output div_valid, div_mantissa, div_exponent, div_sign, div_special,
             div_dest, fpu_div_busy, dbg_state
   );

endinterface

// File: rtl/fpu_divsqrt_step.sv
// One restoring iteration shared by both modes.
// Divide: trial remainder - divisor, remainder shifted left by one.
// Sqrt:   bring in two radicand bits, trial against 4*root + 1.
module fpu_divsqrt_step #(
   parameter int MANT_W = 23
) (
   input  logic              mode,
   input  logic [MANT_W+4:0] rem,
   input  logic [MANT_W:0]   divisor,
   input  logic [MANT_W+2:0] root,
   input  logic [1:0]        rad_pair,
   output logic [MANT_W+4:0] rem_next,
   output logic              q_bit
);
   localparam int RW = MANT_W + 5;

   logic [RW-1:0] cur;
   logic [RW-1:0] sub;
   logic [RW:0]   trial;

   // Trial subtract; a clear borrow bit means the new digit is 1.
   always_comb begin
      if (mode) begin
         cur = {rem[RW-3:0], rad_pair};
         sub = {root, 2'b01};
      end else begin
         cur = rem;
         sub = {{(RW-MANT_W-1){1'b0}}, divisor};
      end
      trial = {1'b0, cur} - {1'b0, sub};
      q_bit = ~trial[RW];
      if (mode)
         rem_next = q_bit ? trial[RW-1:0] : cur;
      else
         rem_next = q_bit ? {trial[RW-2:0], 1'b0} : {cur[RW-2:0], 1'b0};
   end

endmodule

// File: rtl/fpu_divsqrt.sv
// Iterative FP divide / square root producing an unrounded quotient or
// root with sticky bit and a wide signed exponent. Special operands take a
// one-cycle early-out; kill flushes the operation without a result.
module fpu_divsqrt
   import fpu_pkg::*;
#(
   parameter int EXP_W  = FP_EXP_W,
   parameter int MANT_W = FP_MANT_W,
   parameter int DEST_W = 5
) (
   input logic          clock,
   input logic          reset_n,
   fpu_divsqrt_if.slave bus
);
   localparam int N  = MANT_W + 3;
   localparam int RW = MANT_W + 5;
   localparam int EW = EXP_W + 2;
   localparam int CW = $clog2(N + 1);
   localparam logic signed [EW-1:0] BIAS = EW'((2**(EXP_W-1)) - 1);

   div_state_e state, state_nx;
   logic accept, step_en, out_load;

   logic              sa, sb;
   logic [EXP_W-1:0]  ea, eb;
   logic [MANT_W-1:0] ma, mb;
   fp_class_e         ca, cb, spec_cls;
   logic              res_sign;

   logic signed [EW-1:0] ea_x, eb_x, e_unb, exp_init;
   logic [N-1:0]         rad_init;

   logic [CW-1:0]     count;
   logic              mode_r;
   logic [RW-1:0]     rem_r, rem_nx;
   logic [MANT_W:0]   dvsr_r;
   logic [N-1:0]      rad_r, q_r;
   logic [EW-1:0]     exp_r;
   logic              sign_r, q_bit;
   fp_class_e         cls_r;
   logic [DEST_W-1:0] dest_r;

   assign {sa, ea, ma} = bus.fpu_a;
   assign {sb, eb, mb} = bus.fpu_b;
   assign ca = fp_classify(ea == '0, &ea, ma == '0);
   assign cb = fp_classify(eb == '0, &eb, mb == '0);

   assign bus.fpu_div_busy = bus.fpu_div_start | (state != ST_IDLE);
   assign bus.dbg_state    = state;

   // Early-out class and result sign from the incoming operands.
   always_comb begin
      spec_cls = FP_NORMAL;
      res_sign = bus.fpu_div_mode ? 1'b0 : (sa ^ sb);
      if (!bus.fpu_div_mode) begin
         if (ca == FP_NAN || cb == FP_NAN || (ca == FP_ZERO && cb == FP_ZERO) ||
             (ca == FP_INF && cb == FP_INF)) begin
            spec_cls = FP_NAN;
            res_sign = 1'b0;
         end else if (ca == FP_INF || cb == FP_ZERO)
            spec_cls = FP_INF;
         else if (ca == FP_ZERO || cb == FP_INF)
            spec_cls = FP_ZERO;
      end else begin
         if (ca == FP_NAN || (sa && ca != FP_ZERO))
            spec_cls = FP_NAN;
         else if (ca == FP_ZERO) begin
            spec_cls = FP_ZERO;
            res_sign = sa;
         end else if (ca == FP_INF)
            spec_cls = FP_INF;
      end
   end

   // Starting exponent and radicand; odd unbiased exponents pre-shift the
   // radicand so the root exponent is a clean floor(e/2).
   always_comb begin
      ea_x     = $signed({2'b00, ea});
      eb_x     = $signed({2'b00, eb});
      e_unb    = ea_x - BIAS;
      exp_init = bus.fpu_div_mode ? ((e_unb >>> 1) + BIAS) : (ea_x - eb_x + BIAS);
      rad_init = e_unb[0] ? {1'b1, ma, 2'b00} : {2'b01, ma, 1'b0};
   end

   fpu_divsqrt_step #(.MANT_W(MANT_W)) u_step (
      .mode     (mode_r),
      .rem      (rem_r),
      .divisor  (dvsr_r),
      .root     (q_r),
      .rad_pair (rad_r[N-1:N-2]),
      .rem_next (rem_nx),
      .q_bit    (q_bit)
   );

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next state and control strobes; kill overrides everything.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      step_en  = 1'b0;
      out_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.fpu_div_start) begin
               accept   = 1'b1;
               state_nx = (spec_cls != FP_NORMAL) ? ST_SPECIAL : ST_RUN;
            end
         end
         ST_RUN: begin
            step_en = 1'b1;
            if (count == CW'(1)) state_nx = ST_DONE;
         end
         ST_SPECIAL, ST_DONE: begin
            out_load = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (bus.fpu_div_kill) begin
         state_nx = ST_IDLE;
         accept   = 1'b0;
         step_en  = 1'b0;
         out_load = 1'b0;
      end
   end

   // Operand capture on accept, then one iteration per RUN cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count  <= '0;
         mode_r <= 1'b0;
         rem_r  <= '0;
         dvsr_r <= '0;
         rad_r  <= '0;
         q_r    <= '0;
         exp_r  <= '0;
         sign_r <= 1'b0;
         cls_r  <= FP_NORMAL;
         dest_r <= '0;
      end else if (accept) begin
         count  <= CW'(N);
         mode_r <= bus.fpu_div_mode;
         rem_r  <= bus.fpu_div_mode ? '0 : RW'({1'b1, ma});
         dvsr_r <= {1'b1, mb};
         rad_r  <= rad_init;
         q_r    <= '0;
         exp_r  <= exp_init;
         sign_r <= res_sign;
         cls_r  <= spec_cls;
         dest_r <= bus.fpu_dest;
      end else if (step_en) begin
         count <= count - CW'(1);
         rem_r <= rem_nx;
         q_r   <= {q_r[N-2:0], q_bit};
         rad_r <= {rad_r[N-3:0], 2'b00};
      end
   end

   // Result registers: strobe valid for one cycle, hold the fields after.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.div_valid    <= 1'b0;
         bus.div_mantissa <= '0;
         bus.div_exponent <= '0;
         bus.div_sign     <= 1'b0;
         bus.div_special  <= 2'd0;
         bus.div_dest     <= '0;
      end else begin
         bus.div_valid <= out_load;
         if (out_load) begin
            bus.div_mantissa <= (cls_r == FP_NORMAL) ? {q_r, rem_r != '0} : '0;
            bus.div_exponent <= (cls_r == FP_NORMAL) ? exp_r : '0;
            bus.div_sign     <= sign_r;
            bus.div_special  <= cls_r;
            bus.div_dest     <= dest_r;
         end
      end
   end

endmodule

// File: tb/tb_fpu_divsqrt.sv
// Bench for fpu_divsqrt: directed vectors, IEEE specials, kill/reset
// flushes, busy-start protocol, and random normal operands against an
// integer-arithmetic reference model.
module tb_fpu_divsqrt;
   import fpu_pkg::*;

   localparam int W = 64;

   logic clock;
   logic reset_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   proto_err = 0;
   logic [W-1:0] exp_q[$];

   fpu_divsqrt_if #(.EXP_W(8), .MANT_W(23), .DEST_W(5)) bus ();

   fpu_divsqrt #(.EXP_W(8), .MANT_W(23), .DEST_W(5)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Clock and cycle counter.
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint unsigned isqrt(input longint unsigned v);
      longint unsigned r, t;
      r = 0;
      for (int b = 26; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= v) r = t;
      end
      return r;
   endfunction

   // Reference result {mant[26:0], exp[9:0], sign, special[1:0], dest[4:0]}.
   function automatic logic [44:0] model(input logic mode, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] dest);
      logic sa, sb;
      int ea, eb, ue;
      logic [22:0] ma, mb;
      bit a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
      logic [1:0] spec;
      logic sign;
      logic [26:0] mant;
      logic [9:0] ex;
      longint unsigned num, den, q, r, rad;
      sa = a[31]; ea = int'(a[30:23]); ma = a[22:0];
      sb = b[31]; eb = int'(b[30:23]); mb = b[22:0];
      a_zero = (ea == 0); a_inf = (ea == 255 && ma == 0); a_nan = (ea == 255 && ma != 0);
      b_zero = (eb == 0); b_inf = (eb == 255 && mb == 0); b_nan = (eb == 255 && mb != 0);
      mant = '0; ex = '0; spec = 2'd0; sign = 1'b0;
      if (!mode) begin
         sign = sa ^ sb;
         if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec = 2'd3;
            sign = 1'b0;
         end else if (a_inf || b_zero) spec = 2'd2;
         else if (a_zero || b_inf) spec = 2'd1;
         else begin
            num  = 64'({1'b1, ma}) << 25;
            den  = 64'({1'b1, mb});
            q    = num / den;
            r    = num % den;
            mant = {q[25:0], r != 0};
            ex   = 10'(ea - eb + FP_BIAS);
         end
      end else begin
         if (a_nan || (sa && !a_zero)) spec = 2'd3;
         else if (a_zero) begin
            spec = 2'd1;
            sign = sa;
         end else if (a_inf) spec = 2'd2;
         else begin
            ue   = ea - FP_BIAS;
            rad  = 64'({1'b1, ma}) << (ue[0] ? 28 : 27);
            q    = isqrt(rad);
            mant = {q[25:0], q * q != rad};
            ex   = 10'((ue >>> 1) + FP_BIAS);
         end
      end
      return {mant, ex, sign, spec, dest};
   endfunction

   // Scoreboard: every strobe must match the oldest expected result.
   always @(negedge clock) begin
      logic [W-1:0] w;
      if (reset_n && bus.div_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", 64'(bus.div_valid), 64'd0);
         end else begin
            w = exp_q.pop_front();
            check("latency",  64'(cyc), 64'(w[60:45]));
            check("mantissa", 64'(bus.div_mantissa), 64'(w[44:18]));
            check("exponent", 64'(bus.div_exponent), 64'(w[17:8]));
            check("sign",     64'(bus.div_sign), 64'(w[7]));
            check("special",  64'(bus.div_special), 64'(w[6:5]));
            check("dest",     64'(bus.div_dest), 64'(w[4:0]));
         end
      end
   end

   // Protocol monitor: start while the unit is not idle.
   always @(negedge clock) begin
      if (reset_n && bus.fpu_div_start && bus.dbg_state != ST_IDLE) proto_err++;
   end

   // Drive one request for a cycle; push its expected result when it should complete.
   task automatic do_op(input logic mode, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic [44:0] w, input bit push);
      int lat;
      lat = (w[6:5] == 2'd0) ? 27 : 1;
      @(negedge clock);
      bus.fpu_div_start = 1'b1;
      bus.fpu_div_mode  = mode;
      bus.fpu_a         = a;
      bus.fpu_b         = b;
      bus.fpu_dest      = dest;
      @(posedge clock);
      #1;
      if (push) exp_q.push_back({3'b000, 16'(cyc + lat), w});
      bus.fpu_div_start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clock);
         #1;
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic run_op(input logic mode, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic [44:0] w);
      do_op(mode, a, b, dest, w, 1'b1);
      drain(60);
      repeat (3) @(negedge clock);
      check("hold_mant", 64'(bus.div_mantissa), 64'(w[44:18]));
      check("hold_dest", 64'(bus.div_dest), 64'(w[4:0]));
   endtask

   task automatic quiet(input int n);
      repeat (n) @(negedge clock);
   endtask

   logic [31:0] sp_a[7] = '{32'h7F800000, 32'h7FC00001, 32'h40A00000, 32'hFF800000,
                            32'h00000001, 32'h7F800000, 32'h80000001};
   logic [31:0] sp_b[7] = '{32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h40000000,
                            32'h40000000, 32'h00000000, 32'h00000000};
   logic        sp_m[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      reset_n           = 1'b0;
      bus.fpu_div_start = 1'b0;
      bus.fpu_div_mode  = 1'b0;
      bus.fpu_a         = '0;
      bus.fpu_b         = '0;
      bus.fpu_dest      = '0;
      bus.fpu_div_kill  = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_outputs", 64'({bus.div_valid, bus.div_mantissa, bus.div_exponent,
                                  bus.div_sign, bus.div_special, bus.div_dest}), 64'd0);
      check("reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));
      bus.fpu_div_start = 1'b1;
      #1 check("busy_eq_start", 64'(bus.fpu_div_busy), 64'd1);
      bus.fpu_div_start = 1'b0;
      #1 check("busy_idle", 64'(bus.fpu_div_busy), 64'd0);
      reset_n = 1'b1;

      // Directed normal results.
      run_op(1'b0, 32'h40400000, 32'h40000000, 5'd7, {27'h6000000, 10'd127, 1'b0, 2'd0, 5'd7});
      run_op(1'b0, 32'h3F800000, 32'h40400000, 5'd1, {27'h2AAAAAB, 10'd126, 1'b0, 2'd0, 5'd1});
      run_op(1'b1, 32'h40800000, 32'h00000000, 5'd2, {27'h4000000, 10'd128, 1'b0, 2'd0, 5'd2});
      run_op(1'b1, 32'h40000000, 32'h00000000, 5'd3, {27'h5A82799, 10'd127, 1'b0, 2'd0, 5'd3});

      // Directed specials (one-cycle latency).
      run_op(1'b0, 32'h3F800000, 32'h00000000, 5'd4, {27'h0, 10'd0, 1'b0, 2'd2, 5'd4});
      run_op(1'b0, 32'h00000000, 32'h00000000, 5'd5, {27'h0, 10'd0, 1'b0, 2'd3, 5'd5});
      run_op(1'b1, 32'hC0800000, 32'h00000000, 5'd6, {27'h0, 10'd0, 1'b0, 2'd3, 5'd6});
      run_op(1'b1, 32'h80000000, 32'h00000000, 5'd8, {27'h0, 10'd0, 1'b1, 2'd1, 5'd8});

      // Further special combinations through the model.
      for (int i = 0; i < 7; i++)
         run_op(sp_m[i], sp_a[i], sp_b[i], 5'(i + 10), model(sp_m[i], sp_a[i], sp_b[i], 5'(i + 10)));

      // Kill mid-divide: no result, busy drops, next op is clean.
      do_op(1'b0, 32'h40400000, 32'h40000000, 5'd9, '0, 1'b0);
      repeat (8) @(posedge clock);
      @(negedge clock);
      bus.fpu_div_kill = 1'b1;
      @(posedge clock);
      #1;
      bus.fpu_div_kill = 1'b0;
      check("busy_after_kill", 64'(bus.fpu_div_busy), 64'd0);
      quiet(35);
      run_op(1'b0, 32'h40A00000, 32'h40400000, 5'd20, model(1'b0, 32'h40A00000, 32'h40400000, 5'd20));

      // Kill together with start: dropped.
      @(negedge clock);
      bus.fpu_div_start = 1'b1;
      bus.fpu_div_kill  = 1'b1;
      bus.fpu_div_mode  = 1'b0;
      bus.fpu_a         = 32'h40400000;
      bus.fpu_b         = 32'h40000000;
      @(posedge clock);
      #1;
      bus.fpu_div_start = 1'b0;
      bus.fpu_div_kill  = 1'b0;
      check("kill_start_state", 64'(bus.dbg_state), 64'(ST_IDLE));
      quiet(35);

      // Start reasserted while busy: ignored, first op intact.
      do_op(1'b0, 32'h3F800000, 32'h40400000, 5'd21, {27'h2AAAAAB, 10'd126, 1'b0, 2'd0, 5'd21}, 1'b1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      bus.fpu_div_start = 1'b1;
      bus.fpu_div_mode  = 1'b1;
      bus.fpu_a         = 32'h40800000;
      bus.fpu_dest      = 5'd9;
      @(posedge clock);
      #1;
      bus.fpu_div_start = 1'b0;
      drain(60);
      quiet(5);

      // Random normal operands in both modes.
      for (int i = 0; i < 12; i++) begin
         logic m;
         logic [31:0] a, b;
         m = 1'($urandom_range(0, 1));
         a = {m ? 1'b0 : 1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
         b = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
         run_op(m, a, b, 5'(i), model(m, a, b, 5'(i)));
      end

      // Reset pulsed mid-operation: outputs clear, no result.
      do_op(1'b1, 32'h40000000, 32'h00000000, 5'd30, '0, 1'b0);
      repeat (8) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("midop_reset_outputs", 64'({bus.div_valid, bus.div_mantissa, bus.div_exponent,
                                        bus.div_sign, bus.div_special, bus.div_dest}), 64'd0);
      check("midop_reset_busy", 64'(bus.fpu_div_busy), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      quiet(35);

      check("proto_err", 64'(proto_err), 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
